// File: rtl/dec_rr_arbiter_if.sv
// dec_rr_arbiter_if
// Bundles the request/grant signals of the decoder round-robin arbiter.
//   req     : per-requester level request
//   pol_cfg : decoder polarity for the next grant (1 = active-high lines)
//   gnt     : registered one-hot grant
//   gnt_vld : a grant is active
//   dec_a   : decoder drive {A2,A1,A0} = {polarity, owner}
//   tenure  : cycles the current owner has held the grant, 0-based
//   lock    : present only with DEC_ARB_LOCK_EN; holds the current owner
// The slave modport belongs to the arbiter; the master modport to the requesters.
interface dec_rr_arbiter_if #(
  parameter int CNT_W = 3
);
  logic [3:0]       req;
  logic             pol_cfg;
  logic [3:0]       gnt;
  logic             gnt_vld;
  logic [2:0]       dec_a;
  logic [CNT_W-1:0] tenure;
`ifdef DEC_ARB_LOCK_EN
  logic             lock;
`endif

  modport slave (
    input  req,
    input  pol_cfg,
`ifdef DEC_ARB_LOCK_EN
    input  lock,
`endif
    output gnt,
    output gnt_vld,
    output dec_a,
    output tenure
  );

  modport master (
    output req,
    output pol_cfg,
`ifdef DEC_ARB_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  gnt_vld,
    input  dec_a,
    input  tenure
  );
endinterface

// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter
// Round-robin arbiter sharing one four-line polarity decoder among four
// requesters. One owner at a time, tenure bounded by HOLD_MAX while others
// wait, all outputs registered.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : dec_rr_arbiter_if slave modport (req, pol_cfg, gnt, gnt_vld,
//           dec_a, tenure, and lock when DEC_ARB_LOCK_EN is defined)
// Optional feature: define DEC_ARB_LOCK_EN to add the lock input, which
// suppresses tenure expiry while a grant is active.
//
// state   | meaning
// --------+-------------------------------
// S_IDLE  | no owner, dec_a shows last owner
// S_GRANT | r_owner holds the decoder
module dec_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input logic            clk,
  input logic            rst_n,
  dec_rr_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TEN_MAX = CNT_W'(HOLD_MAX - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_owner, w_owner_nxt;
  logic [1:0]       r_last_owner, w_last_nxt;
  logic             r_pol, w_pol_nxt;
  logic [CNT_W-1:0] r_tenure, w_tenure_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic             r_gnt_vld, w_gnt_vld_nxt;
  logic [2:0]       r_dec_a, w_dec_a_nxt;

  logic [3:0]       w_others;
  logic             w_ten_max;
  logic             w_lock;

  // Nearest requester after 'last', wrapping; k=1 is visited last so it wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

`ifdef DEC_ARB_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_others  = bus.req & ~(4'b0001 << r_owner);
  assign w_ten_max = (r_tenure == TEN_MAX);

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last_owner;
    w_pol_nxt    = r_pol;
    w_tenure_nxt = r_tenure;

    case (r_state)
      S_IDLE: begin
        w_tenure_nxt = '0;
        if (|bus.req) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = rr_pick(bus.req, r_last_owner);
          w_last_nxt  = w_owner_nxt;
          w_pol_nxt   = bus.pol_cfg;
        end
      end
      S_GRANT: begin
        if (!bus.req[r_owner]) begin
          // Release wins over expiry; hand off without a bubble if possible.
          w_tenure_nxt = '0;
          if (|w_others) begin
            w_owner_nxt = rr_pick(w_others, r_owner);
            w_last_nxt  = w_owner_nxt;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_ten_max && (|w_others) && !w_lock) begin
          w_owner_nxt  = rr_pick(w_others, r_owner);
          w_last_nxt   = w_owner_nxt;
          w_tenure_nxt = '0;
        end else if (!w_ten_max) begin
          w_tenure_nxt = r_tenure + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_tenure_nxt = '0;
      end
    endcase

    w_gnt_vld_nxt = (w_state_nxt == S_GRANT);
    w_gnt_nxt     = w_gnt_vld_nxt ? (4'b0001 << w_owner_nxt) : 4'b0000;
    // In IDLE the decoder still drives a line; it points at the last owner.
    w_dec_a_nxt   = {w_pol_nxt, (w_gnt_vld_nxt ? w_owner_nxt : w_last_nxt)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd3;
      r_pol        <= 1'b1;
      r_tenure     <= '0;
      r_gnt        <= 4'b0000;
      r_gnt_vld    <= 1'b0;
      r_dec_a      <= 3'b111;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_pol        <= w_pol_nxt;
      r_tenure     <= w_tenure_nxt;
      r_gnt        <= w_gnt_nxt;
      r_gnt_vld    <= w_gnt_vld_nxt;
      r_dec_a      <= w_dec_a_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.dec_a   = r_dec_a;
  assign bus.tenure  = r_tenure;

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// tb_dec_rr_arbiter
// Self-checking bench for dec_rr_arbiter (HOLD_MAX=4, CNT_W=3): a vector
// table of directed cases, hand-written multi-cycle sequences, and random
// stimulus compared against a behavioural model of the arbitration rules.
// Define DEC_ARB_LOCK_EN to also exercise the lock input.
module tb_dec_rr_arbiter;
  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = 3;

  logic       clk;
  logic       t_rst_n;
  logic [3:0] t_req;
  logic       t_pol;
  logic       t_lock;

  int n_checks;
  int n_errors;

  dec_rr_arbiter_if #(.CNT_W(CNT_W)) bus ();

  assign bus.req     = t_req;
  assign bus.pol_cfg = t_pol;
`ifdef DEC_ARB_LOCK_EN
  assign bus.lock    = t_lock;
`endif

  dec_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (t_rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner = -1 means nobody holds the decoder.
  int m_owner;
  int m_last;
  int m_ten;
  bit m_pol;

  function automatic int next_after(input logic [3:0] r, input int after);
    for (int k = 1; k <= 4; k++)
      if (r[(after + k) % 4]) return (after + k) % 4;
    return -1;
  endfunction

  task automatic model_step();
    int others;
    if (!t_rst_n) begin
      m_owner = -1; m_last = 3; m_ten = 0; m_pol = 1'b1;
    end else if (m_owner < 0) begin
      m_ten = 0;
      if (t_req != 4'b0) begin
        m_owner = next_after(t_req, m_last);
        m_last  = m_owner;
        m_pol   = t_pol;
      end
    end else begin
      others = 0;
      for (int i = 0; i < 4; i++)
        if (i != m_owner && t_req[i]) others++;
      if (!t_req[m_owner]) begin
        m_ten = 0;
        if (others > 0) begin
          m_owner = next_after(t_req, m_owner);
          m_last  = m_owner;
        end else begin
          m_owner = -1;
        end
      end else if (m_ten == HOLD_MAX - 1 && others > 0 && !t_lock) begin
        m_owner = next_after(t_req, m_owner);
        m_last  = m_owner;
        m_ten   = 0;
      end else if (m_ten < HOLD_MAX - 1) begin
        m_ten++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    int e_gnt, e_dec;
    e_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
    e_dec = (int'(m_pol) << 2) | ((m_owner >= 0) ? m_owner : m_last);
    chk("model_gnt",     int'(bus.gnt),     e_gnt);
    chk("model_gnt_vld", int'(bus.gnt_vld), (m_owner >= 0) ? 1 : 0);
    chk("model_dec_a",   int'(bus.dec_a),   e_dec);
    chk("model_tenure",  int'(bus.tenure),  m_ten);
  endtask

  // One clock: model follows the same edge, outputs sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       pol;
    logic [3:0] gnt;
    logic       vld;
    logic [2:0] dec;
    logic [2:0] ten;
  } vec_t;

  vec_t vecs[15];

  initial begin
    n_checks = 0;
    n_errors = 0;
    t_rst_n = 1'b0; t_req = 4'b0; t_pol = 1'b1; t_lock = 1'b0;
    m_owner = -1; m_last = 3; m_ten = 0; m_pol = 1'b1;

    //              rst   req      pol   gnt      vld   dec     ten
    vecs[0]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'b111, 3'd0}; // reset
    vecs[1]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 3'b110, 3'd0}; // first grant
    vecs[2]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'b110, 3'd0}; // idle
    vecs[3]  = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 3'b001, 3'd0}; // pol=0 grant 1
    vecs[4]  = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 3'b001, 3'd1}; // pol change ignored
    vecs[5]  = '{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 3'b011, 3'd0}; // release handoff
    vecs[6]  = '{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 3'b011, 3'd1};
    vecs[7]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'b011, 3'd0}; // idle keeps pol 0
    vecs[8]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 3'b100, 3'd0}; // new grant takes pol 1
    vecs[9]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'b100, 3'd0};
    vecs[10] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 3'b110, 3'd0}; // owner 2
    vecs[11] = '{1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1, 3'b110, 3'd1};
    vecs[12] = '{1'b0, 4'b0110, 1'b1, 4'b0000, 1'b0, 3'b111, 3'd0}; // reset mid-grant
    vecs[13] = '{1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 3'b101, 3'd0}; // re-arbitrate from 0
    vecs[14] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'b101, 3'd0};

    for (int v = 0; v < 15; v++) begin
      t_rst_n = vecs[v].rst_n; t_req = vecs[v].req; t_pol = vecs[v].pol;
      cycle();
      chk($sformatf("vec%0d_gnt", v),     int'(bus.gnt),     int'(vecs[v].gnt));
      chk($sformatf("vec%0d_gnt_vld", v), int'(bus.gnt_vld), int'(vecs[v].vld));
      chk($sformatf("vec%0d_dec_a", v),   int'(bus.dec_a),   int'(vecs[v].dec));
      chk($sformatf("vec%0d_tenure", v),  int'(bus.tenure),  int'(vecs[v].ten));
    end

    // All four requesting: 0,1,2,3,0 with HOLD_MAX cycles each.
    t_rst_n = 1'b0; t_req = 4'b0;
    cycle();
    t_rst_n = 1'b1; t_req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("rr_all_gnt",    int'(bus.gnt),    1 << ((k / HOLD_MAX) % 4));
      chk("rr_all_tenure", int'(bus.tenure), k % HOLD_MAX);
    end

    // Uncontended owner: tenure saturates at HOLD_MAX-1.
    t_req = 4'b0;
    cycle();
    t_req = 4'b1000;
    for (int k = 0; k < 8; k++) cycle();
    chk("sat_tenure", int'(bus.tenure), HOLD_MAX - 1);
    chk("sat_gnt",    int'(bus.gnt),    4'b1000);
    // Contention arriving on a saturated owner rotates on the next edge.
    t_req = 4'b1001;
    cycle();
    chk("sat_rotate_gnt", int'(bus.gnt), 4'b0001);

`ifdef DEC_ARB_LOCK_EN
    t_rst_n = 1'b0; t_req = 4'b0;
    cycle();
    t_rst_n = 1'b1; t_req = 4'b0011; t_lock = 1'b1;
    for (int k = 0; k < 2 * HOLD_MAX; k++) cycle();
    chk("lock_hold_gnt",    int'(bus.gnt),    4'b0001);
    chk("lock_hold_tenure", int'(bus.tenure), HOLD_MAX - 1);
    t_lock = 1'b0;
    cycle();
    chk("lock_release_gnt", int'(bus.gnt), 4'b0010);
`endif

    // Random stimulus against the model, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      t_rst_n = ($urandom_range(0, 49) != 0);
      t_req   = 4'($urandom_range(0, 15));
      t_pol   = 1'($urandom_range(0, 1));
`ifdef DEC_ARB_LOCK_EN
      t_lock  = ($urandom_range(0, 3) == 0);
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
